// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage: the fetch FSM
//   state encoding and the default reset PC / PC increment.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // present a request at pc
        WAIT  = 2'd1,   // request outstanding, waiting for imem_ack
        PUSH  = 2'd2,   // word held, try to push into the FIFO
        HOLD  = 2'd3    // word held, FIFO was full, no new request
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// fetch_unit_pc_reg
//   Program-counter register with load (redirect) and increment (advance
//   after a push). Load wins over increment. Arithmetic wraps modulo
//   2^addr_size.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset, loads reset_pc
//   load     load load_pc this cycle
//   load_pc  value to load
//   inc      add pc_step this cycle
//   pc       current program counter
module fetch_unit_pc_reg #(
    parameter int unsigned           addr_size = 32,
    parameter logic [addr_size-1:0]  reset_pc  = '0,
    parameter int unsigned           pc_step   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [addr_size-1:0] load_pc,
    input  logic                 inc,
    output logic [addr_size-1:0] pc
);

    logic [addr_size-1:0] pc_d, pc_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + addr_size'(pc_step);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= reset_pc;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Issues one single-word request at a time to
//   instruction memory, holds the returned word and pushes it into the
//   instruction FIFO when the FIFO is not full. A redirect restarts
//   fetching at redirect_pc and pulses fifo_flush; an outstanding request
//   that cannot be withdrawn is completed and its word dropped.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   imem_req/addr/ack/rdata    instruction memory request/response
//   fifo_full                  FIFO full indication
//   fifo_write_enable/data     registered push strobe and word
//   redirect_valid/pc          branch redirect from execute
//   fifo_flush                 registered one-cycle FIFO discard pulse
//   pc_out                     address of the word on fifo_data
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned          word_size = 32,
    parameter int unsigned          addr_size = 32,
    parameter logic [addr_size-1:0] reset_pc  = addr_size'(RESET_PC_DEFAULT),
    parameter int unsigned          pc_step   = PC_STEP_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [addr_size-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [word_size-1:0] imem_rdata,
    input  logic                 fifo_full,
    output logic                 fifo_write_enable,
    output logic [word_size-1:0] fifo_data,
    input  logic                 redirect_valid,
    input  logic [addr_size-1:0] redirect_pc,
    output logic                 fifo_flush,
    output logic [addr_size-1:0] pc_out
);

    fetch_state_e         state_d, state_q;
    logic                 squash_d, squash_q;
    logic [addr_size-1:0] req_addr_d, req_addr_q;
    logic [word_size-1:0] hold_data_d, hold_data_q;
    logic                 fifo_we_d, fifo_we_q;
    logic [word_size-1:0] fifo_data_d, fifo_data_q;
    logic                 fifo_flush_d, fifo_flush_q;
    logic [addr_size-1:0] pc_out_d, pc_out_q;
    logic [addr_size-1:0] pc_q;
    logic                 pc_load, pc_inc;
    logic                 req_open;

    fetch_unit_pc_reg #(
        .addr_size (addr_size),
        .reset_pc  (reset_pc),
        .pc_step   (pc_step)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc_q)
    );

    // Request is gated by reset so it is low while reset is held, even
    // though the state register already sits in FETCH.
    assign imem_req  = reset && (state_q == FETCH || state_q == WAIT);
    assign imem_addr = (state_q == WAIT) ? req_addr_q : pc_q;

    // A request presented this cycle that memory has not accepted: it must
    // be kept on the bus, so a redirect cannot simply drop it.
    assign req_open  = (state_q == FETCH || state_q == WAIT) && !imem_ack;

    always_comb begin
        state_d      = state_q;
        squash_d     = squash_q;
        req_addr_d   = req_addr_q;
        hold_data_d  = hold_data_q;
        fifo_we_d    = 1'b0;
        fifo_data_d  = fifo_data_q;
        fifo_flush_d = 1'b0;
        pc_out_d     = pc_out_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;

        // Latch the presented address so WAIT keeps it even after pc moves.
        if (state_q == FETCH) begin
            req_addr_d = pc_q;
        end

        if (redirect_valid) begin
            pc_load      = 1'b1;
            fifo_flush_d = 1'b1;
            if (req_open) begin
                // Finish the unaccepted request at its old address, drop its word.
                state_d  = WAIT;
                squash_d = 1'b1;
            end else begin
                state_d  = FETCH;
                squash_d = 1'b0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        hold_data_d = imem_rdata;
                        state_d     = PUSH;
                    end else begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        hold_data_d = imem_rdata;
                        squash_d    = 1'b0;
                        state_d     = squash_q ? FETCH : PUSH;
                    end
                end
                PUSH, HOLD: begin
                    if (!fifo_full) begin
                        fifo_we_d   = 1'b1;
                        fifo_data_d = hold_data_q;
                        pc_out_d    = pc_q;
                        pc_inc      = 1'b1;
                        state_d     = FETCH;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= FETCH;
            squash_q     <= 1'b0;
            req_addr_q   <= reset_pc;
            // NOTE: data holding registers are reset too, so fifo_data has a defined reset value.
            hold_data_q  <= '0;
            fifo_we_q    <= 1'b0;
            fifo_data_q  <= '0;
            fifo_flush_q <= 1'b0;
            pc_out_q     <= reset_pc;
        end else begin
            state_q      <= state_d;
            squash_q     <= squash_d;
            req_addr_q   <= req_addr_d;
            hold_data_q  <= hold_data_d;
            fifo_we_q    <= fifo_we_d;
            fifo_data_q  <= fifo_data_d;
            fifo_flush_q <= fifo_flush_d;
            pc_out_q     <= pc_out_d;
        end
    end

    assign fifo_write_enable = fifo_we_q;
    assign fifo_data         = fifo_data_q;
    assign fifo_flush        = fifo_flush_q;
    assign pc_out            = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Randomized bench for fetch_unit. The reference model states the
//   architectural contract: pushed words form a sequential PC stream
//   starting at reset_pc or at the target of the latest redirect, each
//   word being memory[pc]; every redirect yields exactly one flush, in
//   order. Stimulus queues redirect targets; a negedge monitor pops them on
//   fifo_flush and checks every push against the model.
module tb_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [WW-1:0] imem_rdata = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_write_enable;
    logic [WW-1:0] fifo_data;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          fifo_flush;
    logic [AW-1:0] pc_out;

    fetch_unit #(
        .word_size (WW),
        .addr_size (AW),
        .reset_pc  (RESET_PC),
        .pc_step   (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_data         (fifo_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fifo_flush        (fifo_flush),
        .pc_out            (pc_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents as a pure function of the address.
    function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Scoreboard: redirect targets in issue order, one per expected flush.
    logic [AW-1:0] exp_q[$];

    // Memory responder controls.
    int  max_delay = 0;
    bit  ack_block = 1'b0;
    bit  ack_stray = 1'b0;
    bit  pending   = 1'b0;
    int  delay_left = 0;
    bit  zw_mode   = 1'b0;

    // One clock cycle of stimulus: controls change 1 time unit after the
    // edge, the memory answers 1 unit later once imem_req has settled.
    task automatic tick(input logic rst_v, input logic full_v,
                        input logic redir_v, input logic [AW-1:0] rpc_v);
        @(posedge clk);
        #1;
        reset          = rst_v;
        fifo_full      = full_v;
        redirect_valid = redir_v;
        redirect_pc    = rpc_v;
        if (redir_v && rst_v) exp_q.push_back(rpc_v);
        #1;
        if (ack_stray) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
        end else if (!imem_req || ack_block) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            pending    = 1'b0;
        end else begin
            if (!pending) begin
                pending    = 1'b1;
                delay_left = $urandom_range(max_delay, 0);
            end
            if (delay_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                pending    = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                delay_left--;
            end
        end
    endtask

    // Monitor: at each negedge compare the outputs produced by the last edge
    // with the model, using the inputs that were sampled at that edge.
    logic          p_rst = 1'b0, p_full = 1'b0, p_req = 1'b0, p_ack = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [AW-1:0] cur_pc = RESET_PC;
    int            cyc = 0, last_push = -1, n_push = 0;

    always @(negedge clk) begin
        cyc++;
        if (!p_rst) begin
            check("rst_we",     fifo_write_enable, 0);
            check("rst_flush",  fifo_flush, 0);
            check("rst_data",   fifo_data, 0);
            check("rst_pc_out", pc_out, RESET_PC);
            check("rst_addr",   imem_addr, RESET_PC);
            if (!reset) check("rst_req", imem_req, 0);
            cur_pc    = RESET_PC;
            last_push = -1;
            exp_q.delete();
        end else begin
            if (fifo_flush) begin
                check("flush_not_with_push", fifo_write_enable, 0);
                check("flush_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) cur_pc = exp_q.pop_front();
            end
            if (fifo_write_enable) begin
                check("push_pc",       pc_out, cur_pc);
                check("push_data",     fifo_data, mem_word(cur_pc));
                check("push_not_full", p_full, 0);
                if (zw_mode && last_push >= 0) check("zero_wait_gap", cyc - last_push, 2);
                last_push = cyc;
                cur_pc    = cur_pc + 4;
                n_push++;
            end
            if (p_req && !p_ack && reset) begin
                check("req_held",    imem_req, 1);
                check("addr_stable", imem_addr, p_addr);
            end
        end
        p_rst  = reset;
        p_full = fifo_full;
        p_req  = imem_req;
        p_ack  = imem_ack;
        p_addr = imem_addr;
    end

    initial begin
        logic [AW-1:0] rpc;
        logic [AW-1:0] held_addr;

        // Reset for three cycles, then zero-wait memory, FIFO never full.
        repeat (3) tick(1'b0, 1'b0, 1'b0, '0);
        zw_mode   = 1'b1;
        max_delay = 0;
        tick(1'b1, 1'b0, 1'b0, '0);
        check("first_req",      imem_req, 1);
        check("first_req_addr", imem_addr, RESET_PC);
        repeat (20) tick(1'b1, 1'b0, 1'b0, '0);
        zw_mode = 1'b0;

        // FIFO full: the held word must wait in HOLD with no request.
        repeat (6) tick(1'b1, 1'b1, 1'b0, '0);
        check("hold_no_req", imem_req, 0);
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        check("hold_release_req", imem_req, 1);

        // Redirect while a request is outstanding: address kept until ack.
        ack_block = 1'b1;
        repeat (4) tick(1'b1, 1'b0, 1'b0, '0);
        held_addr = imem_addr;
        tick(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        repeat (2) tick(1'b1, 1'b0, 1'b0, '0);
        check("squash_addr_kept", imem_addr, held_addr);
        ack_block = 1'b0;
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        check("squash_next_req",  imem_req, 1);
        check("squash_next_addr", imem_addr, 32'h0000_0200);
        repeat (6) tick(1'b1, 1'b0, 1'b0, '0);

        // Random traffic: memory latency, FIFO back-pressure, redirects
        // (some targets close to the top of the address space to wrap).
        max_delay = 3;
        for (int i = 0; i < 1500; i++) begin
            logic full_r, redir_r;
            full_r  = ($urandom_range(3, 0) == 0);
            redir_r = ($urandom_range(24, 0) == 0);
            rpc     = ($urandom_range(2, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            tick(1'b1, full_r, redir_r, rpc);
        end
        repeat (12) tick(1'b1, 1'b0, 1'b0, '0);

        // Reset while waiting on memory, with a stray ack during reset.
        ack_block = 1'b1;
        repeat (4) tick(1'b1, 1'b0, 1'b0, '0);
        ack_stray = 1'b1;
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, '0);
        check("reset_req_low", imem_req, 0);
        ack_stray = 1'b0;
        ack_block = 1'b0;
        max_delay = 1;
        repeat (16) tick(1'b1, 1'b0, 1'b0, '0);

        @(negedge clk);
        @(negedge clk);
        check("flushes_all_seen", exp_q.size(), 0);
        check("enough_pushes",    n_push >= 200, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
